// File: rtl/sm4_sbox_pipe.sv
// sm4_sbox_pipe -- multi-lane pipelined SM4 S-box with valid/ready handshaking.
//
// Every byte lane of an accepted beat is substituted through the standard SM4
// S-box. The lookup sits combinationally ahead of stage 0, and stages
// 1..STAGES-1 only delay the result. The stages form an elastic chain, so
// bubbles close up behind a stalled output and no beat is lost or repeated.
//
// Parameters:
//   LANES  : byte lanes per beat (1..16); data width is 8*LANES
//   STAGES : pipeline register stages (1..4); latency in cycles
//
// Ports:
//   clk        : clock, all flops rising-edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : input beat valid
//   in_ready   : block accepts a beat this cycle (no in_valid -> in_ready path)
//   in_data    : lane i = in_data[8i+7:8i]
//   out_valid  : output beat valid
//   out_ready  : downstream accepts the beat this cycle
//   out_data   : lane i = Sbox(input lane i)
//   busy       : OR of all stage valid bits
//
// Optional build macro SM4_SBOX_BIST_EN adds a built-in self-test:
//   bist_start : pulse while busy=0 to run the self-test
//   bist_done  : sticky completion flag, cleared by the next bist_start
//   bist_pass  : self-test result, valid when bist_done=1
module sm4_sbox_pipe #(
   parameter int LANES  = 4,
   parameter int STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef SM4_SBOX_BIST_EN
   input  logic               bist_start,
   output logic               bist_done,
   output logic               bist_pass,
`endif
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_data,
   output logic               busy
);

   localparam int W    = 8 * LANES;
   localparam int LAST = STAGES - 1;

   // S-box table, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'hd690e9fecce13db716b614c228fb2c05,
      128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62,
      128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8,
      128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887,
      128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1,
      128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f,
      128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8,
      128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684,
      128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   // Entry x lives at bit offset (255-x)*8, i.e. {~x, 3'b000}.
   function automatic logic [7:0] sbox_f(input logic [7:0] x);
      logic [10:0] idx;
      idx = {~x, 3'b000};
      return SBOX_TABLE[idx +: 8];
   endfunction

   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] advance_s;
   logic [STAGES-1:0] load_s;
   logic [W-1:0]      data_q [STAGES];
   logic [W-1:0]      data_d [STAGES];
   logic [W-1:0]      lane_in_s;
   logic [W-1:0]      sbox_s;
   logic              in_ready_s;
   logic              stage0_fire_s;
   logic              busy_s;

   // Self-test hooks into the datapath; tied off when the BIST is not built.
   logic              bist_mode_s;
   logic              bist_block_s;
   logic              bist_issue_s;
   logic [7:0]        bist_byte_s;

   assign busy_s = |valid_q;

   // Advance/load chain, walked from the output stage back to stage 0.
   always_comb begin
      logic adv_v;
      advance_s = '0;
      // During self-test the last stage drains every cycle.
      adv_v = bist_mode_s | out_ready;
      for (int k = LAST; k >= 0; k--) begin
         advance_s[k] = adv_v;
         adv_v        = !valid_q[k] || adv_v;
      end
      load_s = ~valid_q | advance_s;
   end

   assign in_ready_s    = load_s[0] && !bist_block_s;
   assign stage0_fire_s = bist_mode_s ? bist_issue_s : (in_valid && in_ready_s);
   assign lane_in_s     = bist_mode_s ? {LANES{bist_byte_s}} : in_data;

   // Per-lane S-box lookup ahead of stage 0.
   always_comb begin
      sbox_s = '0;
      for (int i = 0; i < LANES; i++) begin
         sbox_s[8*i +: 8] = sbox_f(lane_in_s[8*i +: 8]);
      end
   end

   // Next-state of the stage valid bits and data registers.
   always_comb begin
      valid_d = valid_q;
      for (int k = 0; k < STAGES; k++) begin
         data_d[k] = data_q[k];
      end
      if (load_s[0]) begin
         valid_d[0] = stage0_fire_s;
         if (stage0_fire_s) begin
            data_d[0] = sbox_s;
         end else begin
            data_d[0] = data_q[0];
         end
      end else begin
         valid_d[0] = valid_q[0];
      end
      for (int k = 1; k < STAGES; k++) begin
         if (load_s[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
               data_d[k] = data_q[k-1];
            end else begin
               data_d[k] = data_q[k];
            end
         end else begin
            valid_d[k] = valid_q[k];
         end
      end
   end

   // Pipeline stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = valid_q[LAST] && !bist_mode_s;
   assign out_data  = data_q[LAST];
   assign busy      = busy_s;

`ifdef SM4_SBOX_BIST_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } bist_state_t;

   bist_state_t  state_q, state_d;
   logic [8:0]   issue_cnt_q, issue_cnt_d;
   logic [8:0]   rx_cnt_q, rx_cnt_d;
   logic [255:0] seen_q, seen_d;
   logic         lanes_ok_q, lanes_ok_d;
   logic         d6_ok_q, d6_ok_d;
   logic         done_q, done_d;
   logic         pass_q, pass_d;
   logic         start_s;
   logic         rx_s;
   logic         lanes_eq_s;
   logic [7:0]   rx_byte_s;

   assign start_s      = bist_start && !busy_s && (state_q == ST_IDLE);
   assign bist_mode_s  = (state_q != ST_IDLE);
   // The start cycle is blocked too, so no user beat slips in with the test.
   assign bist_block_s = bist_mode_s || start_s;
   assign bist_issue_s = (state_q == ST_RUN) && !issue_cnt_q[8] && load_s[0];
   assign bist_byte_s  = issue_cnt_q[7:0];
   assign rx_s         = bist_mode_s && valid_q[LAST];
   assign rx_byte_s    = data_q[LAST][7:0];

   // All lanes of the beat leaving the pipe must carry the same byte.
   always_comb begin
      lanes_eq_s = 1'b1;
      for (int i = 1; i < LANES; i++) begin
         if (data_q[LAST][8*i +: 8] != rx_byte_s) begin
            lanes_eq_s = 1'b0;
         end else begin
            lanes_eq_s = lanes_eq_s;
         end
      end
   end

   // Self-test sequencer and result checker.
   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      rx_cnt_d    = rx_cnt_q;
      seen_d      = seen_q;
      lanes_ok_d  = lanes_ok_q;
      d6_ok_d     = d6_ok_q;
      done_d      = done_q;
      pass_d      = pass_q;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               state_d     = ST_RUN;
               issue_cnt_d = 9'd0;
               rx_cnt_d    = 9'd0;
               seen_d      = '0;
               lanes_ok_d  = 1'b1;
               d6_ok_d     = 1'b0;
               done_d      = 1'b0;
               pass_d      = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bist_issue_s) begin
               issue_cnt_d = issue_cnt_q + 9'd1;
            end else begin
               issue_cnt_d = issue_cnt_q;
            end
            if (issue_cnt_d[8]) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            state_d = ST_DRAIN;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (rx_s) begin
         seen_d[rx_byte_s] = 1'b1;
         rx_cnt_d          = rx_cnt_q + 9'd1;
         if (!lanes_eq_s) begin
            lanes_ok_d = 1'b0;
         end else begin
            lanes_ok_d = lanes_ok_q;
         end
         // The first beat out is the image of 0x00.
         if (rx_cnt_q == 9'd0) begin
            d6_ok_d = (rx_byte_s == 8'hd6);
         end else begin
            d6_ok_d = d6_ok_q;
         end
      end else begin
         rx_cnt_d = rx_cnt_q;
      end
      if ((state_q == ST_DRAIN) && rx_cnt_d[8]) begin
         state_d = ST_IDLE;
         done_d  = 1'b1;
         pass_d  = (&seen_d) && lanes_ok_d && d6_ok_d;
      end else begin
         done_d = done_d;
      end
   end

   // Self-test state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         issue_cnt_q <= 9'd0;
         rx_cnt_q    <= 9'd0;
         seen_q      <= '0;
         lanes_ok_q  <= 1'b0;
         d6_ok_q     <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         seen_q      <= seen_d;
         lanes_ok_q  <= lanes_ok_d;
         d6_ok_q     <= d6_ok_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

   assign bist_done = done_q;
   assign bist_pass = pass_q;
`else
   assign bist_mode_s  = 1'b0;
   assign bist_block_s = 1'b0;
   assign bist_issue_s = 1'b0;
   assign bist_byte_s  = 8'h00;
`endif

endmodule

// File: tb/tb_sm4_sbox_pipe.sv
// Testbench for sm4_sbox_pipe: random and directed stimulus, scoreboard
// checking against a table-driven reference of the SM4 S-box.
module tb_sm4_sbox_pipe;

   localparam int LANES  = 4;
   localparam int STAGES = 2;
   localparam int W      = 8 * LANES;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         busy;
`ifdef SM4_SBOX_BIST_EN
   logic         bist_start = 1'b0;
   logic         bist_done;
   logic         bist_pass;
`endif

   sm4_sbox_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef SM4_SBOX_BIST_EN
      .bist_start(bist_start),
      .bist_done (bist_done),
      .bist_pass (bist_pass),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Standard SM4 S-box: row = high nibble, column = low nibble (col 0 leftmost).
   logic [127:0] sbox_rows [16] = '{
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   int           total = 0;
   int           bad = 0;
   int           acc_cnt = 0;
   int           out_cnt = 0;
   logic [W-1:0] exp_q [$];
   logic         stall_prev = 1'b0;
   logic [W-1:0] data_prev = '0;

   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [127:0] row;
      int           col;
      row = sbox_rows[x[7:4]];
      col = int'(x[3:0]);
      return row[(15 - col) * 8 +: 8];
   endfunction

   function automatic logic [W-1:0] beat_ref(input logic [W-1:0] d);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) r[8*i +: 8] = sbox_ref(d[8*i +: 8]);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Input side: every accepted beat pushes its expected response.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         exp_q.push_back(beat_ref(in_data));
         acc_cnt++;
      end
   end

   // Output side: pop and compare on every consumed beat; check stall stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'(data_prev));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 64'(out_data), 64'hdead_0000_0000_0000);
            end else begin
               check("scoreboard", 64'(out_data), 64'(exp_q.pop_front()));
            end
            out_cnt <= out_cnt + 1;
         end
         stall_prev <= out_valid && !out_ready;
         data_prev  <= out_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      int guard;
      int target;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_valid2", 64'(out_valid), 64'd0);
`ifdef SM4_SBOX_BIST_EN
      check("rst_bist_done", 64'(bist_done), 64'd0);
      check("rst_bist_pass", 64'(bist_pass), 64'd0);
`endif

      // Spot values and latency.
      out_ready = 1'b1;
      in_data   = 32'h0001_10ff;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c < STAGES; c++) begin
         check("latency_early", 64'(out_valid), 64'd0);
         tick();
      end
      check("latency_valid", 64'(out_valid), 64'd1);
      check("spot_values", 64'(out_data), 64'hd690_2b48);
      tick();

      // Full-rate stream 0x00..0xFF on all lanes.
      base = out_cnt;
      for (int b = 0; b < 256; b++) begin
         in_data  = {LANES{8'(b)}};
         in_valid = 1'b1;
         #1;
         check("stream_ready", 64'(in_ready), 64'd1);
         tick();
      end
      in_valid = 1'b0;
      repeat (STAGES) tick();
      check("stream_count", 64'(out_cnt - base), 64'd256);
      check("stream_idle", 64'(out_valid), 64'd0);

      // Backpressure: only STAGES beats fit.
      out_ready = 1'b0;
      base = acc_cnt;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         tick();
      end
      check("bp_accepted", 64'(acc_cnt - base), 64'(STAGES));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      // Full: accept and consume in the same cycle.
      out_ready = 1'b1;
      in_data   = $urandom;
      #1;
      check("full_pass_ready", 64'(in_ready), 64'd1);
      tick();
      out_ready = 1'b0;
      #1;
      check("full_still_full", 64'(in_ready), 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (STAGES + 2) tick();
      check("bp_drained_busy", 64'(busy), 64'd0);
      check("bp_drained_queue", 64'(exp_q.size()), 64'd0);

      // Random handshake toggling over 1000 beats.
      target = acc_cnt + 1000;
      guard  = 0;
      while (acc_cnt < target && guard < 20000) begin
         in_valid  = 1'($urandom % 2);
         in_data   = $urandom;
         out_ready = 1'($urandom % 2);
         tick();
         guard++;
      end
      check("random_budget", 64'(acc_cnt >= target), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      guard     = 0;
      while (busy && guard < 50) begin
         tick();
         guard++;
      end
      check("random_busy", 64'(busy), 64'd0);
      check("random_queue", 64'(exp_q.size()), 64'd0);
      check("random_counts", 64'(out_cnt), 64'(acc_cnt));

      // Reset with beats in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = $urandom;
      tick();
      in_data = $urandom;
      tick();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      exp_q.delete();
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("postrst_no_output", 64'(out_valid), 64'd0);
      end
      in_valid = 1'b1;
      in_data  = $urandom;
      tick();
      in_valid = 1'b0;
      repeat (STAGES + 1) tick();
      check("postrst_queue", 64'(exp_q.size()), 64'd0);

`ifdef SM4_SBOX_BIST_EN
      // Self-test from idle, with a user beat offered throughout.
      base       = acc_cnt;
      in_valid   = 1'b1;
      in_data    = $urandom;
      bist_start = 1'b1;
      #1;
      check("bist_start_blocks", 64'(in_ready), 64'd0);
      tick();
      bist_start = 1'b0;
      guard      = 1;
      while (!bist_done && guard < 400) begin
         tick();
         guard++;
      end
      in_valid = 1'b0;
      check("bist_done", 64'(bist_done), 64'd1);
      check("bist_pass", 64'(bist_pass), 64'd1);
      check("bist_latency", 64'(guard >= 256 && guard <= 256 + STAGES + 4), 64'd1);
      check("bist_no_accept", 64'(acc_cnt - base), 64'd0);
      tick();
      // Start while busy is ignored; done stays set.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = $urandom;
      tick();
      in_valid   = 1'b0;
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      check("bist_busy_ignored_done", 64'(bist_done), 64'd1);
      check("bist_busy_ignored_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      repeat (STAGES + 2) tick();
      check("bist_busy_drained", 64'(busy), 64'd0);
      check("bist_busy_queue", 64'(exp_q.size()), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
